pll_ce_gen: RTL and testbench

//  Parametrised fractional clock-enable generator. Derives NUM_CH independent clock

---
 rtl/pll_ce_gen.sv | 104 ++++++++++
 tb/tb_pll_ce_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pll_ce_gen.sv
// Fractional clock-enable generator: NUM_CH phase accumulators on refclk, each
// emitting a one-cycle enable on carry-out, with shadowed rates applied atomically.
module pll_ce_gen #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 32,
  parameter int SETTLE = 16,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC = '0,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_apply,
  output logic [NUM_CH-1:0] ce_out,
  output logic              locked
);

  typedef enum logic [1:0] {
    ST_RESTART,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic [ACC_W-1:0] shadow_q [NUM_CH];
  logic [ACC_W-1:0] active_q [NUM_CH];
  logic [ACC_W-1:0] acc_q    [NUM_CH];
  logic [ACC_W:0]   sum      [NUM_CH];
  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] wr_sel;
  logic wr_acc, apply_acc;

  assign cfg_ready = (state_q != ST_RESTART);
  assign locked    = (state_q == ST_RUN);
  assign wr_acc    = cfg_valid & cfg_ready;
  assign apply_acc = cfg_apply & cfg_ready;

  // Out-of-range channel numbers match no wr_sel bit, so the write is dropped.
  always_comb begin
    wr_sel = '0;
    carry  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_acc && (cfg_ch == CH_W'(i));
      sum[i]    = {1'b0, acc_q[i]} + {1'b0, active_q[i]};
      carry[i]  = sum[i][ACC_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESTART: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (cnt_q == 8'(SETTLE - 1)) state_d = ST_RUN;
        else                         cnt_d   = cnt_q + 8'd1;
      end
      ST_RUN: ;
      default: state_d = ST_RESTART;
    endcase
    if (apply_acc) begin
      state_d = ST_SETTLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= ST_RESTART;
      cnt_q   <= '0;
      ce_out  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= INIT_INC[i*ACC_W +: ACC_W];
        active_q[i] <= INIT_INC[i*ACC_W +: ACC_W];
        acc_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Gating on the next state lets the first enable coincide with locked rising.
      ce_out  <= carry & {NUM_CH{state_d == ST_RUN}};
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr_sel[i]) shadow_q[i] <= cfg_inc;
        if (apply_acc) begin
          active_q[i] <= wr_sel[i] ? cfg_inc : shadow_q[i];
          acc_q[i]    <= '0;
        end else if (state_q == ST_RESTART) begin
          acc_q[i] <= '0;
        end else begin
          acc_q[i] <= sum[i][ACC_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_pll_ce_gen.sv
// Directed bench for pll_ce_gen: 5 channels, 8-bit accumulators, SETTLE=4.
module tb_pll_ce_gen;

  localparam int NUM_CH = 5;
  localparam int ACC_W  = 8;
  localparam int SETTLE = 4;
  localparam logic [39:0] INIT_INC = {8'd32, 8'd0, 8'd0, 8'd0, 8'd128};

  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [2:0] cfg_ch = '0;
  logic [7:0] cfg_inc = '0;
  logic cfg_apply = 1'b0;
  logic [4:0] ce_out;
  logic locked;

  int n_checks = 0;
  int n_fail = 0;

  always #5 refclk = ~refclk;

  pll_ce_gen #(
    .NUM_CH  (NUM_CH),
    .ACC_W   (ACC_W),
    .SETTLE  (SETTLE),
    .INIT_INC(INIT_INC)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .cfg_apply(cfg_apply),
    .ce_out   (ce_out),
    .locked   (locked)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [2:0] ch;
    logic [7:0] inc;
    logic       apply;
    logic [4:0] ce;
    logic       lk;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [2:0] ch, input logic [7:0] inc,
                     input logic ap, input logic [4:0] ce, input logic lk, input logic rdy);
    vec_t t;
    t.rst = r; t.valid = v; t.ch = ch; t.inc = inc; t.apply = ap;
    t.ce = ce; t.lk = lk; t.rdy = rdy;
    tbl.push_back(t);
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [2:0] ch, input logic [7:0] inc);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_inc = inc;
    step();
    cfg_valid = 1'b0;
  endtask

  function automatic logic carry_at(input int k, input int inc);
    if (k < 1) return 1'b0;
    return ((k * inc) >> ACC_W) != (((k - 1) * inc) >> ACC_W);
  endfunction

  // Call when the bench sits in cycle 1 after the restarting edge (accs at 0, settle count 0).
  task automatic check_run(input string name, input logic [4:0][7:0] inc, input int ncyc);
    logic [4:0] exp;
    for (int n = 1; n <= ncyc; n++) begin
      for (int i = 0; i < NUM_CH; i++)
        exp[i] = (n >= SETTLE + 1) && carry_at(n - 1, int'(inc[i]));
      chk({name, "_ce"}, 32'(ce_out), 32'(exp));
      chk({name, "_locked"}, 32'(locked), 32'(n >= SETTLE + 1));
      step();
    end
  endtask

  int cnt0, cnt1, cnt2;

  initial begin
    // Reset, write ch0=64 in SETTLE, apply; then write ch3=128 with apply in the same cycle.
    add(1, 0, 0, 0,   0, 5'b00000, 0, 0);
    add(0, 0, 0, 0,   0, 5'b00000, 0, 1);
    add(0, 1, 0, 64,  0, 5'b00000, 0, 1);
    add(0, 0, 0, 0,   1, 5'b00000, 0, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 0, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 0, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 0, 1);
    add(0, 0, 0, 0,   0, 5'b00001, 1, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 1, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 1, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 1, 1);
    add(0, 0, 0, 0,   0, 5'b10001, 1, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 1, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 1, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 1, 1);
    add(0, 0, 0, 0,   0, 5'b00001, 1, 1);
    add(0, 1, 3, 128, 1, 5'b00000, 0, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 0, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 0, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 0, 1);
    add(0, 0, 0, 0,   0, 5'b01001, 1, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 1, 1);
    add(0, 0, 0, 0,   0, 5'b01000, 1, 1);
    add(0, 0, 0, 0,   0, 5'b00000, 1, 1);
    add(0, 0, 0, 0,   0, 5'b11001, 1, 1);

    for (int v = 0; v < tbl.size(); v++) begin
      rst = tbl[v].rst; cfg_valid = tbl[v].valid; cfg_ch = tbl[v].ch;
      cfg_inc = tbl[v].inc; cfg_apply = tbl[v].apply;
      step();
      chk($sformatf("tbl%0d_ce", v), 32'(ce_out), 32'(tbl[v].ce));
      chk($sformatf("tbl%0d_locked", v), 32'(locked), 32'(tbl[v].lk));
      chk($sformatf("tbl%0d_ready", v), 32'(cfg_ready), 32'(tbl[v].rdy));
    end
    rst = 1'b0; cfg_valid = 1'b0; cfg_apply = 1'b0;

    // ch1=96 beside ch0=64; apply once, re-apply two cycles later inside SETTLE.
    wr(3'd1, 8'd96);
    repeat (3) step();
    cfg_apply = 1'b1; step(); cfg_apply = 1'b0;
    step();
    cfg_apply = 1'b1; step(); cfg_apply = 1'b0;
    check_run("realign", {8'd32, 8'd128, 8'd0, 8'd96, 8'd64}, 20);

    // inc=0 never pulses, inc=255 pulses 255 of every 256 cycles.
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd255);
    cfg_apply = 1'b1; step(); cfg_apply = 1'b0;
    repeat (4) step();
    chk("extreme_locked", 32'(locked), 32'd1);
    cnt0 = 0; cnt1 = 0; cnt2 = 0;
    for (int n = 0; n < 256; n++) begin
      cnt0 += int'(ce_out[0]);
      cnt1 += int'(ce_out[1]);
      cnt2 += int'(ce_out[2]);
      step();
    end
    chk("inc64_count", 32'(cnt0), 32'd64);
    chk("inc0_count", 32'(cnt1), 32'd0);
    chk("inc255_count", 32'(cnt2), 32'd255);

    // Shadow writes (last wins, out-of-range dropped) leave the active rate alone until apply.
    wr(3'd0, 8'd16);
    wr(3'd0, 8'd32);
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_inc = 8'd255;
    chk("oor_ready", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
    cnt0 = 0;
    for (int n = 0; n < 16; n++) begin
      cnt0 += int'(ce_out[0]);
      step();
    end
    chk("shadow_only_count", 32'(cnt0), 32'd4);
    cfg_apply = 1'b1; step(); cfg_apply = 1'b0;
    check_run("switch", {8'd32, 8'd128, 8'd255, 8'd0, 8'd32}, 24);

    // Reset mid-RUN discards pending shadow writes and restores INIT_INC.
    wr(3'd0, 8'd200);
    wr(3'd4, 8'd10);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_ce", 32'(ce_out), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    step();
    check_run("post_rst", {8'd32, 8'd0, 8'd0, 8'd0, 8'd128}, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
